// File: rtl/gcore_pkg.sv
// Shared phase-sequencer definitions: state encoding (IDLE, P1..P8),
// phase index constants and decode helpers for the per-phase strobes.
package gcore_pkg;

  // FSM state encoding
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_P1   = 4'd1;
  localparam logic [3:0] ST_P2   = 4'd2;
  localparam logic [3:0] ST_P3   = 4'd3;
  localparam logic [3:0] ST_P4   = 4'd4;
  localparam logic [3:0] ST_P5   = 4'd5;
  localparam logic [3:0] ST_P6   = 4'd6;
  localparam logic [3:0] ST_P7   = 4'd7;
  localparam logic [3:0] ST_P8   = 4'd8;

  // Externally visible phase index (IDLE also reports 0)
  localparam logic [2:0] PH_P1 = 3'd0;
  localparam logic [2:0] PH_P2 = 3'd1;
  localparam logic [2:0] PH_P3 = 3'd2;
  localparam logic [2:0] PH_P4 = 3'd3;
  localparam logic [2:0] PH_P5 = 3'd4;
  localparam logic [2:0] PH_P6 = 3'd5;
  localparam logic [2:0] PH_P7 = 3'd6;
  localparam logic [2:0] PH_P8 = 3'd7;

  typedef struct packed {
    logic pc_en;
    logic opram_en;
    logic mem_req;
    logic mem_en;
    logic acc_en;
    logic led_out_en;
  } strobe_t;

  function automatic logic [2:0] phase_of(input logic [3:0] st);
    logic [2:0] ph;
    case (st)
      ST_P1:   ph = PH_P1;
      ST_P2:   ph = PH_P2;
      ST_P3:   ph = PH_P3;
      ST_P4:   ph = PH_P4;
      ST_P5:   ph = PH_P5;
      ST_P6:   ph = PH_P6;
      ST_P7:   ph = PH_P7;
      ST_P8:   ph = PH_P8;
      default: ph = 3'd0;
    endcase
    return ph;
  endfunction

  function automatic strobe_t strobes_of(input logic [3:0] st);
    strobe_t s;
    s = '0;
    case (st)
      ST_P1:   s.pc_en      = 1'b1;
      ST_P2:   s.opram_en   = 1'b1;
      ST_P3:   s.mem_req    = 1'b1;
      ST_P4:   s.mem_en     = 1'b1;
      ST_P5: begin
        s.pc_en  = 1'b1;
        s.acc_en = 1'b1;
      end
      ST_P8:   s.led_out_en = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cycle_ctrl_wait_timer.sv
// wait_timer: loadable down-counter bounding how long P3 waits for memory.
// expired_o is high during the last permitted wait cycle.
module wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk_in,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  localparam int W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(WAIT_MAX - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load on P3 entry, count down while waiting, hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/cycle_ctrl.sv
// cycle_ctrl: eight-phase instruction cycle sequencer with memory-wait
// timeout, halt at instruction boundary and completed-instruction counter.
// Optional single-step support is enabled by defining CYCLE_CTRL_STEP_EN.
module cycle_ctrl
  import gcore_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic             step,
  input  logic             mem_rdy,
  output logic             pc_en,
  output logic             opram_en,
  output logic             mem_req,
  output logic             mem_en,
  output logic             acc_en,
  output logic             led_out_en,
  output logic             busy,
  output logic [2:0]       phase,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  logic [3:0]       state_q, state_d;
  logic             err_q, err_d;
  logic             halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  strobe_t          strb_q;
  logic             busy_q;
  logic [2:0]       phase_q;
  logic             wait_expired;
  logic             step_go;

`ifdef CYCLE_CTRL_STEP_EN
  logic step_q;

  // Step edge detector: previous sample of the step input
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // A step only launches from an idle, error-free, non-running controller
  assign step_go = step & ~step_q & ~run;
`else
  logic unused_step;
  assign unused_step = step;
  assign step_go     = 1'b0;
`endif

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk_in    (clk_in),
    .rst       (rst),
    .load_i    (state_q == ST_P2),
    .dec_i     (state_q == ST_P3),
    .expired_o (wait_expired)
  );

  // Next-state, error, halt-pending and instruction-count logic
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (!run) begin
      err_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (!err_q && ((run && !halt_req) || step_go)) begin
          state_d = ST_P1;
        end
      end
      ST_P1: state_d = ST_P2;
      ST_P2: state_d = ST_P3;
      ST_P3: begin
        if (mem_rdy) begin
          state_d = ST_P4;
        end else if (wait_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_P4: state_d = ST_P5;
      ST_P5: state_d = ST_P6;
      ST_P6: state_d = ST_P7;
      ST_P7: state_d = ST_P8;
      ST_P8: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (run && !halt_req && !halt_pend_q) ? ST_P1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A halt seen anywhere mid-instruction is remembered until the boundary
    if ((state_q == ST_IDLE) || (state_q == ST_P8) || (state_d == ST_IDLE)) begin
      halt_pend_d = 1'b0;
    end else begin
      halt_pend_d = halt_pend_q | halt_req;
    end
  end

  // State and registered outputs, decoded from the upcoming state
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
      cnt_q       <= '0;
      strb_q      <= '0;
      busy_q      <= 1'b0;
      phase_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      halt_pend_q <= halt_pend_d;
      cnt_q       <= cnt_d;
      strb_q      <= strobes_of(state_d);
      busy_q      <= (state_d != ST_IDLE);
      phase_q     <= phase_of(state_d);
    end
  end

  assign pc_en      = strb_q.pc_en;
  assign opram_en   = strb_q.opram_en;
  assign mem_req    = strb_q.mem_req;
  assign mem_en     = strb_q.mem_en;
  assign acc_en     = strb_q.acc_en;
  assign led_out_en = strb_q.led_out_en;
  assign busy       = busy_q;
  assign phase      = phase_q;
  assign err        = err_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_cycle_ctrl.sv
// Directed bench for cycle_ctrl. Counter is built 4 bits wide so the
// all-ones -> zero wrap is reachable in a short run.
module tb_cycle_ctrl;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       run, halt_req, step, mem_rdy;
  logic       pc_en, opram_en, mem_req, mem_en, acc_en, led_out_en;
  logic       busy, err;
  logic [2:0] phase;
  logic [3:0] instr_cnt;
  logic [5:0] strb;
  logic [5:0] stb_tbl [8];

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  assign strb = {pc_en, opram_en, mem_req, mem_en, acc_en, led_out_en};

  cycle_ctrl #(
    .WAIT_MAX (15),
    .CNT_W    (4)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .run        (run),
    .halt_req   (halt_req),
    .step       (step),
    .mem_rdy    (mem_rdy),
    .pc_en      (pc_en),
    .opram_en   (opram_en),
    .mem_req    (mem_req),
    .mem_en     (mem_en),
    .acc_en     (acc_en),
    .led_out_en (led_out_en),
    .busy       (busy),
    .phase      (phase),
    .err        (err),
    .instr_cnt  (instr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int  cyc, mreq, men_at;
    bit  done;

    // strobes {pc,opram,mem_req,mem_en,acc,led} per phase P1..P8
    stb_tbl[0] = 6'b100000;
    stb_tbl[1] = 6'b010000;
    stb_tbl[2] = 6'b001000;
    stb_tbl[3] = 6'b000100;
    stb_tbl[4] = 6'b100010;
    stb_tbl[5] = 6'b000000;
    stb_tbl[6] = 6'b000000;
    stb_tbl[7] = 6'b000001;

    rst = 1'b0; run = 1'b0; halt_req = 1'b0; step = 1'b0; mem_rdy = 1'b0;
    #12;
    chk("rst_strobes", 32'(strb), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(instr_cnt), 0);
    $display("[tb] reset state checked");

    // A: free run with memory always ready
    @(negedge clk_in);
    rst = 1'b1; run = 1'b1; mem_rdy = 1'b1;
    tick();
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("A_phase_c%0d", p + 1), 32'(phase), 32'(p));
      chk($sformatf("A_strb_c%0d", p + 1), 32'(strb), 32'(stb_tbl[p]));
      chk($sformatf("A_busy_c%0d", p + 1), 32'(busy), 1);
      if (p < 7) tick();
    end
    tick();
    chk("A_c9_pc_en", 32'(pc_en), 1);
    chk("A_c9_phase", 32'(phase), 0);
    chk("A_c9_cnt", 32'(instr_cnt), 1);
    $display("[tb] A: back-to-back instruction, cnt=%0d", instr_cnt);

    // B: memory ready delayed 5 cycles in P3
    mem_rdy = 1'b0;
    cyc = 1; mreq = 0; men_at = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      cyc++;
      if (mem_req) begin
        mreq++;
        if (mreq == 6) mem_rdy = 1'b1;
      end
      if (mem_en) men_at = cyc;
      if (led_out_en) done = 1'b1;
    end
    chk("B_done", 32'(done), 1);
    chk("B_mreq_cycles", 32'(mreq), 6);
    chk("B_mem_en_cycle", 32'(men_at), 9);
    chk("B_instr_len", 32'(cyc), 13);
    tick();
    chk("B_cnt", 32'(instr_cnt), 2);
    $display("[tb] B: delayed memory, len=%0d mem_req=%0d", cyc, mreq);

    // C: memory never ready -> timeout after 15 P3 cycles
    mem_rdy = 1'b0;
    tick();
    chk("C_p2", 32'(phase), 1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("C_mem_req_%0d", k), 32'(mem_req), 1);
    end
    chk("C_err_before", 32'(err), 0);
    tick();
    chk("C_err", 32'(err), 1);
    chk("C_busy", 32'(busy), 0);
    chk("C_phase", 32'(phase), 0);
    chk("C_strobes", 32'(strb), 0);
    chk("C_cnt", 32'(instr_cnt), 2);
    ticks(3);
    chk("C_stuck_busy", 32'(busy), 0);
    chk("C_stuck_err", 32'(err), 1);
    run = 1'b0;
    tick();
    chk("C_err_cleared", 32'(err), 0);
    mem_rdy = 1'b1;
    $display("[tb] C: timeout flagged and cleared");

    // D: halt pulsed during P2
    run = 1'b1;
    tick();
    chk("D_p1_pc_en", 32'(pc_en), 1);
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("D_p3", 32'(phase), 2);
    ticks(5);
    chk("D_p8_led", 32'(led_out_en), 1);
    tick();
    run = 1'b0;
    chk("D_busy", 32'(busy), 0);
    chk("D_phase", 32'(phase), 0);
    chk("D_cnt", 32'(instr_cnt), 3);
    $display("[tb] D: halt at boundary, cnt=%0d", instr_cnt);

    // E: run dropped mid-instruction
    run = 1'b1;
    tick();
    run = 1'b0;
    ticks(7);
    chk("E_p8", 32'(phase), 7);
    tick();
    chk("E_busy", 32'(busy), 0);
    chk("E_cnt", 32'(instr_cnt), 4);
    $display("[tb] E: run drop completes instruction");

    // F: reset asserted during P5
    run = 1'b1;
    ticks(5);
    chk("F_p5_strb", 32'(strb), 32'(6'b100010));
    rst = 1'b0;
    #1;
    chk("F_rst_strobes", 32'(strb), 0);
    chk("F_rst_busy", 32'(busy), 0);
    chk("F_rst_phase", 32'(phase), 0);
    chk("F_rst_cnt", 32'(instr_cnt), 0);
    $display("[tb] F: asynchronous reset mid-instruction");

    // G: counter wrap from all-ones to zero
    @(negedge clk_in);
    rst = 1'b1;
    ticks(8 * 15);
    chk("G_p8_of_15", 32'(phase), 7);
    tick();
    chk("G_cnt_max", 32'(instr_cnt), 15);
    ticks(8);
    chk("G_cnt_wrap", 32'(instr_cnt), 0);
    run = 1'b0;
    ticks(8);
    chk("G_idle", 32'(busy), 0);
    chk("G_cnt_after", 32'(instr_cnt), 1);
    $display("[tb] G: counter wrap");

    // H: single step
    step = 1'b1;
    tick();
    step = 1'b0;
`ifdef CYCLE_CTRL_STEP_EN
    chk("H_step_p1", 32'(pc_en), 1);
    ticks(2);
    step = 1'b1;
    tick();
    step = 1'b0;
    ticks(5);
    chk("H_step_idle", 32'(busy), 0);
    chk("H_step_cnt", 32'(instr_cnt), 2);
    ticks(12);
    chk("H_no_second", 32'(busy), 0);
    chk("H_cnt_final", 32'(instr_cnt), 2);
    $display("[tb] H: single step ran one instruction");
`else
    ticks(3);
    chk("H_step_ignored", 32'(busy), 0);
    chk("H_cnt_unchanged", 32'(instr_cnt), 1);
    $display("[tb] H: step ignored in default build");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
